cnt_bank: RTL and testbench

Parametrised bank of NUM_CH independent WIDTH-bit counters with a register-file style access port. Each channel counts external tick pulses up or down against a programmable terminal value, with wrap or saturate behaviour and a one-cycle terminal-count pulse. It is the general-purpose successor to the fixed 4-bit counter and 4x4 register file. It serves timers, event counters and rate dividers in the datapath.

---
 rtl/cnt_bank.sv | 160 ++++++++++++++++
 tb/tb_cnt_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_bank.sv
// cnt_bank: bank of NUM_CH independent WIDTH-bit up/down counters with a
// register-file style write/read port. Each channel steps on its tick strobe
// toward a programmable limit, with wrap or saturate at the terminal value,
// and emits a one-cycle terminal-count pulse on tc.
// Optional feature macro: CNT_BANK_SNAPSHOT_EN adds the snap input and a
// per-channel shadow register readable with rsel == 3.
module cnt_bank #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] tick,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [1:0]        wsel,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [1:0]        rsel,
`ifdef CNT_BANK_SNAPSHOT_EN
    input  logic              snap,
`endif
    output logic [WIDTH-1:0]  rdata,
    output logic [NUM_CH-1:0] tc
);

    localparam logic [1:0] SEL_COUNT = 2'd0;
    localparam logic [1:0] SEL_LIMIT = 2'd1;
    localparam logic [1:0] SEL_CTRL  = 2'd2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Flattened views of every channel's registers for the read mux.
    logic [NUM_CH*WIDTH-1:0] count_all;
    logic [NUM_CH*WIDTH-1:0] limit_all;
    logic [NUM_CH*3-1:0]     ctrl_all;
`ifdef CNT_BANK_SNAPSHOT_EN
    logic [NUM_CH*WIDTH-1:0] shadow_all;
`endif

    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] count_q, count_d;
            logic [WIDTH-1:0] limit_q, limit_d;
            logic [2:0]       ctrl_q, ctrl_d;   // {sat, dir, en}
            logic             tc_q, tc_d;
            logic             wr_hit;
            logic             step;
            logic             at_term;

            // Addresses beyond NUM_CH never match a channel, so such writes drop out here.
            assign wr_hit  = we && (waddr == ADDR_W'(gi));
            assign step    = tick[gi] && ctrl_q[0];
            // Terminal test always uses the start-of-cycle count and limit.
            assign at_term = ctrl_q[1] ? (count_q == '0) : (count_q >= limit_q);

            // Next count and tc: a count write beats a same-cycle step and suppresses tc.
            always_comb begin
                count_d = count_q;
                tc_d    = 1'b0;
                if (wr_hit && (wsel == SEL_COUNT)) begin
                    count_d = wdata;
                end else if (step) begin
                    if (at_term) begin
                        tc_d = 1'b1;
                        if (ctrl_q[2]) begin
                            count_d = ctrl_q[1] ? '0 : limit_q;
                        end else begin
                            count_d = ctrl_q[1] ? limit_q : '0;
                        end
                    end else begin
                        count_d = ctrl_q[1] ? (count_q - ONE) : (count_q + ONE);
                    end
                end
            end

            // Limit and ctrl writes land after this cycle's step has used the old values.
            always_comb begin
                limit_d = limit_q;
                ctrl_d  = ctrl_q;
                if (wr_hit && (wsel == SEL_LIMIT)) begin
                    limit_d = wdata;
                end
                if (wr_hit && (wsel == SEL_CTRL)) begin
                    ctrl_d = wdata[2:0];
                end
            end

            // Channel state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                    limit_q <= '1;
                    ctrl_q  <= 3'b000;
                    tc_q    <= 1'b0;
                end else begin
                    count_q <= count_d;
                    limit_q <= limit_d;
                    ctrl_q  <= ctrl_d;
                    tc_q    <= tc_d;
                end
            end

            assign count_all[gi*WIDTH +: WIDTH] = count_q;
            assign limit_all[gi*WIDTH +: WIDTH] = limit_q;
            assign ctrl_all[gi*3 +: 3]          = ctrl_q;
            assign tc[gi]                       = tc_q;

`ifdef CNT_BANK_SNAPSHOT_EN
            logic [WIDTH-1:0] shadow_q;

            // Shadow captures the pre-step count of this cycle when snap is high.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q <= '0;
                end else if (snap) begin
                    shadow_q <= count_q;
                end
            end

            assign shadow_all[gi*WIDTH +: WIDTH] = shadow_q;
`endif
        end
    endgenerate

    // Read mux over start-of-cycle register values; unmapped channels read 0.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (raddr == ADDR_W'(k)) begin
                case (rsel)
                    SEL_COUNT: rdata_d = count_all[k*WIDTH +: WIDTH];
                    SEL_LIMIT: rdata_d = limit_all[k*WIDTH +: WIDTH];
                    SEL_CTRL:  rdata_d = {{(WIDTH-3){1'b0}}, ctrl_all[k*3 +: 3]};
`ifdef CNT_BANK_SNAPSHOT_EN
                    default:   rdata_d = shadow_all[k*WIDTH +: WIDTH];
`else
                    default:   rdata_d = '0;
`endif
                endcase
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_cnt_bank.sv
// Self-checking bench for cnt_bank: directed scenarios plus randomized traffic,
// checked every cycle against an array-based behavioural model of the bank.
module tb_cnt_bank;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;
    localparam int MOD    = 1 << WIDTH;
    localparam int MAXV   = MOD - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] tick;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [1:0]        wsel;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        rsel;
    logic              snap;
    logic [WIDTH-1:0]  rdata;
    logic [NUM_CH-1:0] tc;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_count  [NUM_CH];
    int m_limit  [NUM_CH];
    int m_ctrl   [NUM_CH];
    int m_shadow [NUM_CH];

    always #5 clk = ~clk;

    cnt_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .we    (we),
        .waddr (waddr),
        .wsel  (wsel),
        .wdata (wdata),
        .raddr (raddr),
        .rsel  (rsel),
`ifdef CNT_BANK_SNAPSHOT_EN
        .snap  (snap),
`endif
        .rdata (rdata),
        .tc    (tc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_read(input int ch, input int sel);
        if (ch >= NUM_CH) return 0;
        case (sel)
            0: return m_count[ch];
            1: return m_limit[ch];
            2: return m_ctrl[ch];
`ifdef CNT_BANK_SNAPSHOT_EN
            default: return m_shadow[ch];
`else
            default: return 0;
`endif
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_count[c]  = 0;
            m_limit[c]  = MAXV;
            m_ctrl[c]   = 0;
            m_shadow[c] = 0;
        end
    endtask

    // Apply the currently driven inputs for one clock and check rdata and tc.
    task automatic cycle();
        int exp_rd;
        int exp_tc;
        int old[NUM_CH];
        exp_rd = rst ? 0 : model_read(int'(raddr), int'(rsel));
        exp_tc = 0;
        if (rst) begin
            model_reset();
        end else begin
            old = m_count;
            for (int c = 0; c < NUM_CH; c++) begin
                bit en, down, sat, hit;
                en   = (m_ctrl[c] & 1) != 0;
                down = (m_ctrl[c] & 2) != 0;
                sat  = (m_ctrl[c] & 4) != 0;
                hit  = we && (int'(waddr) == c);
                if (hit && wsel == 2'd0) begin
                    m_count[c] = int'(wdata);
                end else if (tick[c] && en) begin
                    if (!down) begin
                        if (old[c] >= m_limit[c]) begin
                            exp_tc |= (1 << c);
                            m_count[c] = sat ? m_limit[c] : 0;
                        end else begin
                            m_count[c] = (old[c] + 1) % MOD;
                        end
                    end else begin
                        if (old[c] == 0) begin
                            exp_tc |= (1 << c);
                            m_count[c] = sat ? 0 : m_limit[c];
                        end else begin
                            m_count[c] = old[c] - 1;
                        end
                    end
                end
                if (hit && wsel == 2'd1) m_limit[c] = int'(wdata);
                if (hit && wsel == 2'd2) m_ctrl[c]  = int'(wdata) & 7;
`ifdef CNT_BANK_SNAPSHOT_EN
                if (snap) m_shadow[c] = old[c];
`endif
            end
        end
        @(posedge clk);
        #1;
        check_eq("rdata", rdata, exp_rd);
        check_eq("tc", tc, exp_tc);
    endtask

    task automatic idle();
        rst   = 1'b0;
        tick  = '0;
        we    = 1'b0;
        waddr = '0;
        wsel  = 2'd0;
        wdata = '0;
        raddr = '0;
        rsel  = 2'd0;
        snap  = 1'b0;
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        idle();
        we    = 1'b1;
        waddr = ADDR_W'(ch);
        wsel  = 2'(sel);
        wdata = WIDTH'(data);
        cycle();
    endtask

    task automatic rd_expect(input string tag, input int ch, input int sel, input int exp);
        idle();
        raddr = ADDR_W'(ch);
        rsel  = 2'(sel);
        cycle();
        check_eq(tag, rdata, exp);
    endtask

    task automatic tk(input int mask, input int rch);
        idle();
        tick  = NUM_CH'(mask);
        raddr = ADDR_W'(rch);
        cycle();
    endtask

    initial begin
        int pulses;
        idle();
        model_reset();

        // Reset with activity on every input
        rst = 1'b1; tick = '1; we = 1'b1; wsel = 2'd1; wdata = 8'h12;
        cycle();
        for (int c = 0; c < NUM_CH; c++) begin
            rd_expect("rst_count", c, 0, 0);
            rd_expect("rst_limit", c, 1, 255);
            rd_expect("rst_ctrl",  c, 2, 0);
        end
        check_eq("rst_tc", tc, 0);
        for (int i = 0; i < 3; i++) tk(7, 0);
        rd_expect("dis_count", 0, 0, 0);

        // Ch0 up/wrap at limit 3: 1,2,3,0,1 with a single tc
        wr(0, 1, 3);
        wr(0, 2, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tk(1, 0);
            if (tc[0]) pulses++;
        end
        check_eq("ch0_tc_pulses", pulses, 1);
        rd_expect("ch0_count", 0, 0, 1);

        // Ch1 down/sat from 2: 1,0,0,0 with two tc pulses, then wrap to limit
        wr(1, 2, 7);
        wr(1, 0, 2);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tk(2, 1);
            if (tc[1]) pulses++;
        end
        check_eq("ch1_tc_pulses", pulses, 2);
        rd_expect("ch1_sat0", 1, 0, 0);
        wr(1, 2, 3);
        tk(2, 1);
        rd_expect("ch1_wrap", 1, 0, 255);

        // Ch2 count write colliding with tick and a read
        wr(2, 2, 1);
        tk(4, 2);
        tk(4, 2);
        idle();
        tick = 3'b100; we = 1'b1; waddr = 2'd2; wsel = 2'd0; wdata = 8'h40;
        raddr = 2'd2; rsel = 2'd0;
        cycle();
        check_eq("coll_old", rdata, 2);
        check_eq("coll_tc", tc[2], 0);
        rd_expect("coll_new", 2, 0, 'h40);

        // Writes to unmapped channel and reserved field are ignored
        wr(3, 0, 9);
        wr(3, 1, 9);
        wr(3, 2, 7);
        wr(0, 3, 99);
        rd_expect("unmap_rd", 3, 0, 0);
        rd_expect("unmap_ch0", 0, 0, 1);

        // Reset mid-count overrides tick and we
        tk(7, 0);
        idle();
        rst = 1'b1; tick = '1; we = 1'b1; wsel = 2'd1; wdata = 8'h05;
        cycle();
        check_eq("midrst_tc", tc, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_expect("midrst_count", c, 0, 0);
            rd_expect("midrst_limit", c, 1, 255);
            rd_expect("midrst_ctrl",  c, 2, 0);
        end
        rd_expect("rsv_read", 0, 3, 0);

`ifdef CNT_BANK_SNAPSHOT_EN
        // Snapshot captures pre-step counts while counts advance
        wr(0, 0, 5);
        wr(1, 0, 9);
        wr(0, 2, 1);
        wr(1, 2, 1);
        idle();
        snap = 1'b1; tick = 3'b011; raddr = 2'd0; rsel = 2'd3;
        cycle();
        check_eq("snap_old", rdata, 0);
        rd_expect("snap_ch0", 0, 3, 5);
        rd_expect("snap_ch1", 1, 3, 9);
        rd_expect("snap_cnt0", 0, 0, 6);
        rd_expect("snap_cnt1", 1, 0, 10);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            tick  = NUM_CH'($urandom);
            we    = ($urandom_range(0, 2) == 0);
            waddr = ADDR_W'($urandom);
            wsel  = 2'($urandom);
            wdata = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
            raddr = ADDR_W'($urandom);
            rsel  = 2'($urandom);
            snap  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
